// File: rtl/regfile_decode.sv
// Decode stage with integrated register file: classifies an instruction, reads
// its operands (with write-back bypass), forms the immediate, and registers the bundle.
module regfile_decode #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ra_o,
    output logic [XLEN-1:0] rb_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      itype_o,
    output logic [AW-1:0]   rd_o,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_U = 7'b0110111;

    localparam logic [4:0] IT_R   = 5'b00001;
    localparam logic [4:0] IT_I   = 5'b00010;
    localparam logic [4:0] IT_S   = 5'b00100;
    localparam logic [4:0] IT_U   = 5'b01000;
    localparam logic [4:0] IT_ILL = 5'b10000;

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // Upstream offers ir_i with in_valid; this stage takes it when in_ready.
    // The bundle stays valid and frozen until downstream raises out_ready.

    logic [XLEN-1:0] regs [2**AW];
    logic            wb_hit;
    logic            accept;

    logic [AW-1:0]   rs1, rs2, rd_f;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;
    logic            bad_rs1, bad_rs2, bad_rd;

    logic [XLEN-1:0] ra_n, rb_n, imm_n;
    logic [4:0]      itype_n;
    logic [AW-1:0]   rd_n;

    assign rs1  = ir_i[19:15];
    assign rs2  = ir_i[24:20];
    assign rd_f = ir_i[11:7];

    assign wb_hit = wb_en_i && (wb_addr_i != '0) && (int'(wb_addr_i) < NREG);

    assign in_ready = reset || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Entries at or above NREG are never written, so they stay constant zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) regs[AW'(i)] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) rs1_val = (wb_hit && wb_addr_i == rs1) ? wb_data_i : regs[rs1];
        if (rs2 != '0) rs2_val = (wb_hit && wb_addr_i == rs2) ? wb_data_i : regs[rs2];
    end

    assign imm_i = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
    assign imm_s = {{(XLEN-12){ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_u = {{(XLEN-31){ir_i[31]}}, ir_i[30:12], 12'b0};

    assign bad_rs1 = int'(rs1)  >= NREG;
    assign bad_rs2 = int'(rs2)  >= NREG;
    assign bad_rd  = int'(rd_f) >= NREG;

    // Only the indices an instruction class actually uses can make it illegal.
    always_comb begin
        itype_n = IT_ILL;
        ra_n    = '0;
        rb_n    = '0;
        imm_n   = '0;
        rd_n    = '0;
        unique case (ir_i[6:0])
            OP_R: if (!(bad_rs1 || bad_rs2 || bad_rd)) begin
                itype_n = IT_R;
                ra_n    = rs1_val;
                rb_n    = rs2_val;
                rd_n    = rd_f;
            end
            OP_I: if (!(bad_rs1 || bad_rd)) begin
                itype_n = IT_I;
                ra_n    = rs1_val;
                rb_n    = imm_i;
                imm_n   = imm_i;
                rd_n    = rd_f;
            end
            OP_S: if (!(bad_rs1 || bad_rs2)) begin
                itype_n = IT_S;
                ra_n    = rs1_val;
                rb_n    = rs2_val;
                imm_n   = imm_s;
            end
            OP_U: if (!bad_rd) begin
                itype_n = IT_U;
                rb_n    = imm_u;
                imm_n   = imm_u;
                rd_n    = rd_f;
            end
            default: ;
        endcase
    end

    // Payload loads only on accept, so a stalled bundle ignores later write-backs.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            ra_o      <= '0;
            rb_o      <= '0;
            imm_o     <= '0;
            itype_o   <= '0;
            rd_o      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ra_o      <= ra_n;
            rb_o      <= rb_n;
            imm_o     <= imm_n;
            itype_o   <= itype_n;
            rd_o      <= rd_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_decode.sv
// Directed bench for regfile_decode: a vector table applied through both a
// 32-register and a 16-register instance, plus stall, streaming and reset sequences.
module tb_regfile_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] ir_i;
    logic        out_ready;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;

    logic        in_ready, out_valid;
    logic [31:0] ra_o, rb_o, imm_o;
    logic [4:0]  itype_o, rd_o;

    logic        in_ready16, out_valid16;
    logic [31:0] ra16, rb16, imm16;
    logic [4:0]  itype16, rd16;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    regfile_decode #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ir_i(ir_i), .out_valid(out_valid), .out_ready(out_ready),
        .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o), .itype_o(itype_o), .rd_o(rd_o),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
    );

    regfile_decode #(.XLEN(32), .NREG(16), .AW(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .ir_i(ir_i), .out_valid(out_valid16), .out_ready(out_ready),
        .ra_o(ra16), .rb_o(rb16), .imm_o(imm16), .itype_o(itype16), .rd_o(rd16),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] ir;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] imm;
        logic [4:0]  itype;
        logic [4:0]  rd;
        logic        ill16;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_back(input logic [4:0] addr, input logic [31:0] data);
        wb_en_i   = 1'b1;
        wb_addr_i = addr;
        wb_data_i = data;
        step();
        wb_en_i   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; ir_i = '0; out_ready = 1'b1;
        wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;

        //                ir            wb  addr   data           ra            rb            imm           itype     rd     ill16
        vecs[0]  = '{32'h005281B3, 1'b0, 5'd0, 32'h0,      32'h7,      32'h7,        32'h0,        5'b00001, 5'd3,  1'b0};
        vecs[1]  = '{32'hFFF00093, 1'b0, 5'd0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00010, 5'd1,  1'b0};
        vecs[2]  = '{32'h00548213, 1'b1, 5'd9, 32'h1234,   32'h1234,   32'h5,        32'h5,        5'b00010, 5'd4,  1'b0};
        vecs[3]  = '{32'h00500213, 1'b1, 5'd0, 32'hDEAD,   32'h0,      32'h5,        32'h5,        5'b00010, 5'd4,  1'b0};
        vecs[4]  = '{32'h00548533, 1'b0, 5'd0, 32'h0,      32'h1234,   32'h7,        32'h0,        5'b00001, 5'd10, 1'b0};
        vecs[5]  = '{32'hFE512E23, 1'b0, 5'd0, 32'h0,      32'h100,    32'h7,        32'hFFFFFFFC, 5'b00100, 5'd0,  1'b0};
        vecs[6]  = '{32'h80001337, 1'b0, 5'd0, 32'h0,      32'h0,      32'h80001000, 32'h80001000, 5'b01000, 5'd6,  1'b0};
        vecs[7]  = '{32'h00528180, 1'b0, 5'd0, 32'h0,      32'h0,      32'h0,        32'h0,        5'b10000, 5'd0,  1'b1};
        vecs[8]  = '{32'h014281B3, 1'b0, 5'd0, 32'h0,      32'h7,      32'h55,       32'h0,        5'b00001, 5'd3,  1'b1};
        vecs[9]  = '{32'h000018B7, 1'b0, 5'd0, 32'h0,      32'h0,      32'h1000,     32'h1000,     5'b01000, 5'd17, 1'b1};
        vecs[10] = '{32'h002285B3, 1'b1, 5'd2, 32'h2222,   32'h7,      32'h2222,     32'h0,        5'b00001, 5'd11, 1'b0};

        // reset
        #1;
        check("in_ready_during_reset", in_ready, 1'b1);
        step(); step();
        check("out_valid_during_reset", out_valid, 1'b0);
        reset = 1'b0;
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ra", ra_o, 32'h0);
        check("rst_rb", rb_o, 32'h0);
        check("rst_imm", imm_o, 32'h0);
        check("rst_itype", itype_o, 5'b00000);
        check("rst_rd", rd_o, 5'd0);

        write_back(5'd5, 32'h7);
        write_back(5'd2, 32'h100);
        write_back(5'd20, 32'h55);

        // vector table
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid  = 1'b1;
            ir_i      = vecs[i].ir;
            wb_en_i   = vecs[i].wb_en;
            wb_addr_i = vecs[i].wb_addr;
            wb_data_i = vecs[i].wb_data;
            step();
            in_valid = 1'b0;
            wb_en_i  = 1'b0;
            check($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("v%0d_itype", i), itype_o, vecs[i].itype);
            check($sformatf("v%0d_ra", i), ra_o, vecs[i].ra);
            check($sformatf("v%0d_rb", i), rb_o, vecs[i].rb);
            check($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
            check($sformatf("v%0d_rd", i), rd_o, vecs[i].rd);
            if (vecs[i].ill16) begin
                check($sformatf("v%0d_n16_itype", i), itype16, 5'b10000);
                check($sformatf("v%0d_n16_ra", i), ra16, 32'h0);
                check($sformatf("v%0d_n16_rb", i), rb16, 32'h0);
                check($sformatf("v%0d_n16_rd", i), rd16, 5'd0);
            end else begin
                check($sformatf("v%0d_n16_itype", i), itype16, vecs[i].itype);
                check($sformatf("v%0d_n16_ra", i), ra16, vecs[i].ra);
                check($sformatf("v%0d_n16_rb", i), rb16, vecs[i].rb);
                check($sformatf("v%0d_n16_rd", i), rd16, vecs[i].rd);
            end
        end
        step();
        check("drain_out_valid", out_valid, 1'b0);

        // stall with a write-back to a held operand, then release with no bubble
        in_valid = 1'b1; ir_i = 32'h005281B3; out_ready = 1'b0;
        step();
        ir_i = 32'hFFF00093;
        wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h99;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
            check($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
            check($sformatf("stall%0d_ra", c), ra_o, 32'h7);
            check($sformatf("stall%0d_rd", c), rd_o, 5'd3);
            check($sformatf("stall%0d_itype", c), itype_o, 5'b00001);
            step();
            wb_en_i = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        step();
        check("release_out_valid", out_valid, 1'b1);
        check("release_itype", itype_o, 5'b00010);
        check("release_rd", rd_o, 5'd1);
        check("release_rb", rb_o, 32'hFFFFFFFF);

        // back-to-back stream of lui instructions
        for (int k = 0; k < 4; k++) begin
            logic [4:0] rdk;
            rdk = 5'(12 + k);
            ir_i = {20'h00003, rdk, 7'b0110111};
            exp_q.push_back(rdk);
            step();
            check($sformatf("stream%0d_out_valid", k), out_valid, 1'b1);
            check($sformatf("stream%0d_rd", k), rd_o, exp_q.pop_front());
            check($sformatf("stream%0d_imm", k), imm_o, 32'h3000);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_out_valid", out_valid, 1'b0);

        // reset over a pending bundle and a write-back
        in_valid = 1'b1; ir_i = 32'h005281B3; out_ready = 1'b0;
        step();
        check("pre_reset_ra", ra_o, 32'h99);
        reset = 1'b1;
        wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hAAAA;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        step();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_ra", ra_o, 32'h0);
        check("reset_itype", itype_o, 5'b00000);
        reset = 1'b0; wb_en_i = 1'b0; out_ready = 1'b1;
        step();
        check("post_reset_out_valid", out_valid, 1'b1);
        check("post_reset_ra_x5", ra_o, 32'h0);
        check("post_reset_rb_x5", rb_o, 32'h0);
        check("post_reset_itype", itype_o, 5'b00001);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
